data_recover: RTL and testbench

DATA_RECOVER -- requirements
Module: data_recover

---
 rtl/data_sel_pkg.sv | 13 +
 rtl/data_recover_solve.sv | 32 +++
 rtl/data_recover.sv | 74 +++++++
 tb/tb_data_recover.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/data_sel_pkg.sv
// data_sel_pkg: shared tags, FSM states, widths and range helper for data_recover
package data_sel_pkg;
  localparam int OP_W  = 8;
  localparam int RES_W = 9;
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_DIFF = 2'b11;
  typedef enum logic [1:0] {IDLE, ONE, CALC, HOLD} state_t;
  function automatic logic in_range(input logic signed [9:0] x);
    return (x >= -10'sd128) && (x <= 10'sd127);
  endfunction
endpackage

// File: rtl/data_recover_solve.sv
// data_recover_solve: recovers operands a/b from two tagged results and flags inconsistencies
module data_recover_solve
  import data_sel_pkg::*;
(
  input  logic                    has_a,
  input  logic                    has_b,
  input  logic                    has_s,
  input  logic signed [RES_W-1:0] va,
  input  logic signed [RES_W-1:0] vb,
  input  logic signed [RES_W-1:0] vs,
  input  logic signed [RES_W-1:0] vd,
  output logic signed [OP_W-1:0]  a,
  output logic signed [OP_W-1:0]  b,
  output logic                    err
);
  logic signed [9:0] wa, wb, ws, wd, sum, dif, a10, b10;
  // Widen to 10 bits so sums/differences of 9-bit words cannot overflow; the
  // {s,d} case is the only one where neither operand is held directly.
  always_comb begin
    wa  = {va[RES_W-1], va};
    wb  = {vb[RES_W-1], vb};
    ws  = {vs[RES_W-1], vs};
    wd  = {vd[RES_W-1], vd};
    sum = ws + wd;
    dif = ws - wd;
    a10 = has_a ? wa : has_b ? (has_s ? ws - wb : wd + wb) : sum >>> 1;
    b10 = has_b ? wb : has_a ? (has_s ? ws - wa : wa - wd) : dif >>> 1;
    err = !in_range(a10) || !in_range(b10) || (!has_a && !has_b && sum[0]);
    a   = a10[OP_W-1:0];
    b   = b10[OP_W-1:0];
  end
endmodule

// File: rtl/data_recover.sv
// data_recover: collects two distinct tagged results and emits the recovered operand pair
module data_recover
  import data_sel_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             select,
  input  logic signed [RES_W-1:0] c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [OP_W-1:0] a_out,
  output logic signed [OP_W-1:0] b_out,
  output logic                   err
);
  state_t state, state_nx;
  logic [3:0] flags;
  logic signed [RES_W-1:0] vals [4];
  logic acc, s_err;
  logic signed [OP_W-1:0] s_a, s_b;
  assign acc = in_valid && in_ready;
  data_recover_solve u_solve (
    .has_a(flags[SEL_A]),
    .has_b(flags[SEL_B]),
    .has_s(flags[SEL_SUM]),
    .va(vals[SEL_A]),
    .vb(vals[SEL_B]),
    .vs(vals[SEL_SUM]),
    .vd(vals[SEL_DIFF]),
    .a(s_a),
    .b(s_b),
    .err(s_err)
  );
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next state: second distinct tag triggers the one-cycle solve
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = acc ? ONE : IDLE;
      ONE:  state_nx = (acc && !flags[select]) ? CALC : ONE;
      CALC: state_nx = HOLD;
      HOLD: state_nx = out_ready ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE) || (state == ONE);
    out_valid = state == HOLD;
  end
  // Tag values need no reset: the flags alone decide which are meaningful
  always_ff @(posedge clk)
    if (acc) vals[select] <= c;
  // Tag flags and registered result pair
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flags <= '0;
      a_out <= '0;
      b_out <= '0;
      err   <= 1'b0;
    end else begin
      if (acc) flags <= (state == IDLE ? 4'b0 : flags) | (4'b1 << select);
      if (state == CALC) begin
        a_out <= s_a;
        b_out <= s_b;
        err   <= s_err;
      end
      if (state == HOLD && out_ready) flags <= '0;
    end
endmodule

// File: tb/tb_data_recover.sv
// tb_data_recover: directed self-checking bench for data_recover
module tb_data_recover;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] select = 2'b00;
  logic signed [8:0] c = '0;
  logic in_ready, out_valid, err;
  logic signed [7:0] a_out, b_out;
  int n_chk = 0, n_fail = 0;

  data_recover dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .err(err)
  );

  always #5 clk = ~clk;

  // Presents one word for one rising edge; call just after a falling edge.
  task automatic send(input logic [1:0] s, input logic signed [8:0] v);
    select = s; c = v; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Checks latency and contents of a pair, then consumes it.
  task automatic take(input string name, input logic signed [7:0] ea,
                      input logic signed [7:0] eb, input logic ee);
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s early_valid got %b want 0", name, out_valid); end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s out_valid got %b want 1", name, out_valid); end
    n_chk++;
    if (a_out !== ea) begin n_fail++; $display("FAIL %s a_out got %0d want %0d", name, a_out, ea); end
    n_chk++;
    if (b_out !== eb) begin n_fail++; $display("FAIL %s b_out got %0d want %0d", name, b_out, eb); end
    n_chk++;
    if (err !== ee) begin n_fail++; $display("FAIL %s err got %b want %b", name, err, ee); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s release valid/ready got %b/%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({out_valid, err, a_out, b_out, in_ready} !== {1'b0, 1'b0, 8'd0, 8'd0, 1'b1}) begin
      n_fail++; $display("FAIL reset_state got v=%b e=%b a=%0d b=%0d r=%b want 0 0 0 0 1",
                         out_valid, err, a_out, b_out, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_solve();
    send(2'b10, 9'sd8);   send(2'b11, 9'sd2);    take("sd", 8'sd5, 8'sd3, 1'b0);
    send(2'b01, -9'sd20); send(2'b10, 9'sd30);   take("bs", 8'sd50, -8'sd20, 1'b0);
    send(2'b01, 9'sd10);  send(2'b11, -9'sd5);   take("bd", 8'sd5, 8'sd10, 1'b0);
    send(2'b00, 9'sd12);  send(2'b01, -9'sd7);   take("ab", 8'sd12, -8'sd7, 1'b0);
    send(2'b11, 9'sd40);  send(2'b00, 9'sd15);   take("ad", 8'sd15, -8'sd25, 1'b0);
  endtask

  task automatic test_errors();
    send(2'b10, 9'sd9);   send(2'b11, 9'sd2);    take("parity", 8'sd5, 8'sd3, 1'b1);
    send(2'b10, -9'sd256); send(2'b11, 9'sd0);   take("ext_min", -8'sd128, -8'sd128, 1'b0);
    send(2'b00, 9'sd127); send(2'b11, -9'sd1);   take("ext_b128", 8'sd127, -8'sd128, 1'b1);
    send(2'b00, -9'sd50); send(2'b11, 9'sd100);  take("b_low", -8'sd50, 8'sd106, 1'b1);
    send(2'b00, 9'sd200); send(2'b01, 9'sd0);    take("a_tag_rng", -8'sd56, 8'sd0, 1'b1);
  endtask

  task automatic test_overwrite();
    send(2'b00, 9'sd4);
    send(2'b00, 9'sd100);
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL overwrite_ready got %b want 1", in_ready); end
    send(2'b10, 9'sd0);
    take("overwrite", 8'sd100, -8'sd100, 1'b0);
  endtask

  task automatic test_backpressure();
    send(2'b00, 9'sd20); send(2'b01, 9'sd30);
    @(negedge clk);
    select = 2'b11; c = 9'sd77; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || a_out !== 8'sd20 || b_out !== 8'sd30 || err !== 1'b0) begin
        n_fail++; $display("FAIL hold_%0d got r=%b v=%b a=%0d b=%0d e=%b want 0 1 20 30 0",
                           i, in_ready, out_valid, a_out, b_out, err);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release got v=%b r=%b want 0 1", out_valid, in_ready);
    end
    send(2'b01, 9'sd1);
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL no_capture_ready got %b want 1", in_ready); end
    send(2'b00, 9'sd2);
    take("no_capture", 8'sd2, 8'sd1, 1'b0);
  endtask

  task automatic test_async_reset();
    send(2'b00, 9'sd5);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, err, a_out, b_out, in_ready} !== {1'b0, 1'b0, 8'd0, 8'd0, 1'b1}) begin
      n_fail++; $display("FAIL async_reset got v=%b e=%b a=%0d b=%0d r=%b want 0 0 0 0 1",
                         out_valid, err, a_out, b_out, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b01, 9'sd7); send(2'b00, -9'sd3);
    take("after_reset", -8'sd3, 8'sd7, 1'b0);
    send(2'b00, 9'sd9); send(2'b01, 9'sd9);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || a_out !== 8'sd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_reset got v=%b a=%0d r=%b want 0 0 1", out_valid, a_out, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b10, 9'sd4); send(2'b11, 9'sd2);
    take("after_hold_reset", 8'sd3, 8'sd1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_solve();
    test_errors();
    test_overwrite();
    test_backpressure();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
